usart_bus_arbiter: RTL

//  Shares the single USART register bus (write_enable/address/data_in/data_out) between
//  N_REQ requesters (e.g. CPU port and DMA/config engine). Round-robin arbitration,
//  one transaction in flight. Sequences each write (1 bus cycle) or read (issue + capture).

---
 rtl/usart_bus_pkg.sv | 36 +++
 rtl/usart_bus_arbiter_if.sv | 39 +++
 rtl/usart_rr_picker.sv | 54 +++++
 rtl/usart_bus_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/usart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usart_bus_pkg
// Purpose  : Shared types and constants for the USART register-bus arbiter
//            and the USART register file it fronts.
// Contents : arb_state_e     - arbiter FSM state encoding
//            USART_ADDR_W/DATA_W - register bus widths
//            USART_REG_*     - register addresses of the USART register file
//            rr_next()       - round-robin pointer advance helper
// Revision : 1.0 - initial release
// ============================================================================
package usart_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  localparam int USART_ADDR_W = 8;
  localparam int USART_DATA_W = 8;

  localparam logic [USART_ADDR_W-1:0] USART_REG_CTRL   = 8'h00;
  localparam logic [USART_ADDR_W-1:0] USART_REG_STATUS = 8'h01;
  localparam logic [USART_ADDR_W-1:0] USART_REG_BAUD   = 8'h02;
  localparam logic [USART_ADDR_W-1:0] USART_REG_TXDATA = 8'h03;
  localparam logic [USART_ADDR_W-1:0] USART_REG_RXDATA = 8'h05;

  // Pointer to the requester after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usart_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : usart_bus_arbiter_if
// Purpose  : Requester-side handshake plus USART register-bus signals of the
//            arbiter, bundled into one interface.
// Modports : slave  - arbiter view (takes requests, drives the USART bus)
//            master - environment view (requesters and USART register file)
// Signals  : req/req_we/req_addr/req_wdata, gnt/done/rdata,
//            bus_write_enable/bus_address/bus_data_in/bus_data_out
// Revision : 1.0 - initial release
// ============================================================================
interface usart_bus_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       rdata;
  logic                    bus_write_enable;
  logic [ADDR_W-1:0]       bus_address;
  logic [DATA_W-1:0]       bus_data_in;
  logic [DATA_W-1:0]       bus_data_out;

  modport slave (
    input  req, req_we, req_addr, req_wdata, bus_data_out,
    output gnt, done, rdata, bus_write_enable, bus_address, bus_data_in
  );

  modport master (
    output req, req_we, req_addr, req_wdata, bus_data_out,
    input  gnt, done, rdata, bus_write_enable, bus_address, bus_data_in
  );
endinterface
`default_nettype wire

// File: rtl/usart_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : usart_rr_picker
// Purpose  : Combinational round-robin winner selection: first set request
//            at or after ptr, wrapping.
//            With USART_BUS_ARB_PRIO_EN defined, requester 0 always wins when
//            requesting and the rotation covers requesters 1..N_REQ-1 only.
// Ports    : req       in  N_REQ  request vector
//            ptr       in  PTR_W  rotation start index
//            win_idx   out PTR_W  winning requester
//            win_valid out 1      any request present
// Revision : 1.0 - initial release
// ============================================================================
module usart_rr_picker #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_valid
);

  always_comb begin
    int w_cand;
    w_cand    = 0;
    win_idx   = '0;
    win_valid = 1'b0;
`ifdef USART_BUS_ARB_PRIO_EN
    if (req[0]) begin
      win_valid = 1'b1;
    end else begin
      // Scan from the farthest offset down so the nearest candidate wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        w_cand = (int'(ptr) + k) % N_REQ;
        if (w_cand != 0 && req[w_cand]) begin
          win_idx   = PTR_W'(w_cand);
          win_valid = 1'b1;
        end
      end
    end
`else
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = (int'(ptr) + k) % N_REQ;
      if (req[w_cand]) begin
        win_idx   = PTR_W'(w_cand);
        win_valid = 1'b1;
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/usart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usart_bus_arbiter
// Purpose  : Shares the USART register bus among N_REQ requesters with
//            round-robin arbitration, one transaction in flight. A write
//            takes one bus cycle; a read issues the address and captures the
//            returned data one cycle later.
//            Build option USART_BUS_ARB_PRIO_EN: requester 0 has fixed top
//            priority, rotation among the remaining requesters.
// Ports    : clk    in  1    system clock (rising edge)
//            rst_n  in  1    asynchronous active-low reset
//            bif    slave    request handshake (req/gnt/done/rdata) and
//                            USART bus (bus_write_enable/address/data_in/out)
// Revision : 1.0 - initial release
// ============================================================================
module usart_bus_arbiter
  import usart_bus_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = USART_ADDR_W,
  parameter int DATA_W = USART_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  usart_bus_arbiter_if.slave  bif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] c_ST_IDLE    = IDLE;
  localparam logic [1:0] c_ST_ISSUE   = ISSUE;
  localparam logic [1:0] c_ST_CAPTURE = CAPTURE;
  localparam logic [1:0] c_ST_DONE    = DONE;

  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_idx;
  logic              r_we;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_din;

  logic [PTR_W-1:0]  w_win_idx;
  logic              w_win_valid;
  logic [N_REQ-1:0]  w_win_onehot;
  logic [N_REQ-1:0]  w_idx_onehot;

  usart_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req       (bif.req),
    .ptr       (r_ptr),
    .win_idx   (w_win_idx),
    .win_valid (w_win_valid)
  );

  always_comb begin
    w_win_onehot            = '0;
    w_win_onehot[w_win_idx] = 1'b1;
    w_idx_onehot            = '0;
    w_idx_onehot[r_idx]     = 1'b1;
  end

  // The bus address/data registers double as the latched request fields, so
  // they naturally hold their last value while the arbiter is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_bus_we   <= 1'b0;
      r_bus_addr <= '0;
      r_bus_din  <= '0;
    end else begin
      r_gnt    <= '0;
      r_done   <= '0;
      r_bus_we <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_win_valid) begin
            r_idx      <= w_win_idx;
            r_we       <= bif.req_we[w_win_idx];
            r_gnt      <= w_win_onehot;
            r_bus_we   <= bif.req_we[w_win_idx];
            r_bus_addr <= bif.req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
            r_bus_din  <= bif.req_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
            r_state    <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          if (r_we) begin
            r_done  <= w_idx_onehot;
            r_state <= c_ST_DONE;
          end else begin
            r_state <= c_ST_CAPTURE;
          end
        end
        c_ST_CAPTURE: begin
          // USART read data is valid one cycle after the address was issued.
          r_rdata <= bif.bus_data_out;
          r_done  <= w_idx_onehot;
          r_state <= c_ST_DONE;
        end
        c_ST_DONE: begin
          r_ptr   <= PTR_W'(rr_next(int'(r_idx), N_REQ));
          r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bif.gnt              = r_gnt;
  assign bif.done             = r_done;
  assign bif.rdata            = r_rdata;
  assign bif.bus_write_enable = r_bus_we;
  assign bif.bus_address      = r_bus_addr;
  assign bif.bus_data_in      = r_bus_din;

endmodule
`default_nettype wire
